y_tile_row_to_sram: RTL and testbench

Row writeback engine: on `start_k`, takes row `k_idx` (N elements of DATA_W) out of a flat result tile and writes it into the tile SRAM as N single-word write beats, n = 0..N-1. It is the write-side counterpart of the SRAM-to-tile row loader and drives the same SRAM port shape (en/re/we/k/n/wdata/wmask), with an added grant for stalls. Completion is reported with a level `row_done` held until `row_ack`.

---
 rtl/tpu_tile_pkg.sv | 26 ++
 rtl/y_tile_row_to_sram_if.sv | 33 +++
 rtl/row_snapshot_buf.sv | 33 +++
 rtl/y_tile_row_to_sram.sv | 132 +++++++++++++
 tb/tb_y_tile_row_to_sram.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_tile_pkg.sv
// rtl/tpu_tile_pkg.sv - shared tile constants, writeback state enum and element offset helper
//
// Purpose: common definitions for the tile row engines.
// Contents: default tile geometry (TILE_N, TILE_KMAX, TILE_DATA_W),
//           writeback FSM state type wb_state_t, elem_off() bit-offset helper.
package tpu_tile_pkg;

  localparam int TILE_N      = 8;
  localparam int TILE_KMAX   = 1024;
  localparam int TILE_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  // Bit offset of element (k,n) in a flat row-major tile.
  function automatic int unsigned elem_off(input int unsigned k,
                                           input int unsigned n,
                                           input int unsigned row_n  = TILE_N,
                                           input int unsigned data_w = TILE_DATA_W);
    return (k * row_n + n) * data_w;
  endfunction

endpackage

// File: rtl/y_tile_row_to_sram_if.sv
// rtl/y_tile_row_to_sram_if.sv - tile SRAM write-port interface with grant
//
// Purpose: bundles the SRAM port shared with the row loader, plus y_gnt.
// Signals: y_en/y_we/y_re request strobes, y_k/y_n beat address,
//          y_wdata/y_wmask beat data and byte mask, y_gnt SRAM accept.
// Modports: master (engine side, drives request), slave (SRAM side, drives y_gnt).
interface y_tile_row_to_sram_if #(
  parameter int K_W    = 10,
  parameter int N_W    = 3,
  parameter int DATA_W = 32
);
  localparam int BYTE_W = DATA_W / 8;

  logic              y_en;
  logic              y_we;
  logic              y_re;
  logic [K_W-1:0]    y_k;
  logic [N_W-1:0]    y_n;
  logic [DATA_W-1:0] y_wdata;
  logic [BYTE_W-1:0] y_wmask;
  logic              y_gnt;

  modport master (
    output y_en, y_we, y_re, y_k, y_n, y_wdata, y_wmask,
    input  y_gnt
  );

  modport slave (
    input  y_en, y_we, y_re, y_k, y_n, y_wdata, y_wmask,
    output y_gnt
  );

endinterface

// File: rtl/row_snapshot_buf.sv
// rtl/row_snapshot_buf.sv - N-entry row capture register with column read mux
//
// Purpose: holds a private copy of one tile row so the source may change
//          after the row is accepted.
// Ports: clk, rst (sync, active-high), cap_en (load cap_row),
//        cap_row (N*DATA_W row image, element n at bit n*DATA_W),
//        rd_n (column select), rd_data (selected element).
module row_snapshot_buf #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int N_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic [N*DATA_W-1:0]   cap_row,
  input  logic [N_W-1:0]        rd_n,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < N; i++) mem[i] <= cap_row[i*DATA_W +: DATA_W];
    end
  end

  assign rd_data = mem[rd_n];

endmodule

// File: rtl/y_tile_row_to_sram.sv
// rtl/y_tile_row_to_sram.sv - writes one row of a flat result tile into the tile SRAM
//
// Purpose: on start_k, emits N single-word write beats (n = 0..N-1) for row
//          k_idx, stalling on y_gnt, then holds row_done until row_ack.
// Ports: clk, rst (sync, active-high), start_k/k_idx (row request, IDLE only),
//        busy (WRITE or DONE), row_done/row_ack (completion level + ack),
//        Y_tile_flat (element (k,n) at bit (k*N+n)*DATA_W),
//        sram (y_tile_row_to_sram_if master: en/we/re/k/n/wdata/wmask, gnt).
// Build option: YROW_SNAPSHOT_EN copies the row at start into row_snapshot_buf;
//               otherwise beat data is read live from Y_tile_flat.
module y_tile_row_to_sram
  import tpu_tile_pkg::*;
#(
  parameter  int N      = TILE_N,
  parameter  int KMAX   = TILE_KMAX,
  parameter  int DATA_W = TILE_DATA_W,
  localparam int BYTE_W = DATA_W / 8,
  localparam int N_W    = (N > 1) ? $clog2(N) : 1,
  localparam int K_W    = (KMAX > 1) ? $clog2(KMAX) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_k,
  input  logic [K_W-1:0]             k_idx,
  output logic                       busy,
  output logic                       row_done,
  input  logic                       row_ack,
  input  logic [KMAX*N*DATA_W-1:0]   Y_tile_flat,
  y_tile_row_to_sram_if.master       sram
);

  localparam int FLAT_W = KMAX * N * DATA_W;
  localparam int OFF_W  = (FLAT_W > 1) ? $clog2(FLAT_W) : 1;
  localparam logic [N_W-1:0] N_LAST = N_W'(N - 1);

  wb_state_t         state, state_nxt;
  logic [K_W-1:0]    k_r, k_nxt;
  logic [N_W-1:0]    n_r, n_nxt;
  logic [K_W-1:0]    k_legal;
  logic [DATA_W-1:0] beat_word;
  logic              wr;

  // Rows past KMAX-1 only exist when KMAX is not a power of two; fold them to row 0.
  generate
    if ((1 << K_W) == KMAX) begin : g_k_full
      assign k_legal = k_idx;
    end else begin : g_k_mask
      assign k_legal = (int'(k_idx) < KMAX) ? k_idx : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k_r   <= '0;
      n_r   <= '0;
    end else begin
      state <= state_nxt;
      k_r   <= k_nxt;
      n_r   <= n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k_r;
    n_nxt     = n_r;
    case (state)
      IDLE: begin
        if (start_k) begin
          state_nxt = WRITE;
          k_nxt     = k_legal;
          n_nxt     = '0;
        end
      end
      WRITE: begin
        if (sram.y_gnt) begin
          if (n_r == N_LAST) state_nxt = DONE;
          else               n_nxt     = n_r + 1'b1;
        end
      end
      DONE: begin
        // A start arriving with the ack is dropped; only IDLE accepts starts.
        if (row_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef YROW_SNAPSHOT_EN
  logic [OFF_W-1:0]    row_off;
  logic [N*DATA_W-1:0] cap_row;
  logic                cap_en;

  assign cap_en  = (state == IDLE) && start_k;
  assign row_off = OFF_W'(elem_off(32'(k_legal), 0, N, DATA_W));
  assign cap_row = Y_tile_flat[row_off +: N*DATA_W];

  row_snapshot_buf #(
    .N      (N),
    .DATA_W (DATA_W),
    .N_W    (N_W)
  ) u_snap (
    .clk     (clk),
    .rst     (rst),
    .cap_en  (cap_en),
    .cap_row (cap_row),
    .rd_n    (n_r),
    .rd_data (beat_word)
  );
`else
  // No private copy: the source must keep row k_r stable until row_done.
  logic [OFF_W-1:0] beat_off;

  assign beat_off  = OFF_W'(elem_off(32'(k_r), 32'(n_r), N, DATA_W));
  assign beat_word = Y_tile_flat[beat_off +: DATA_W];
`endif

  // Every port output decodes straight from state/k_r/n_r, so a stalled beat
  // holds and reset clears all of them on the following cycle.
  assign wr           = (state == WRITE);
  assign sram.y_en    = wr;
  assign sram.y_we    = wr;
  assign sram.y_re    = 1'b0;
  assign sram.y_k     = wr ? k_r : '0;
  assign sram.y_n     = wr ? n_r : '0;
  assign sram.y_wdata = wr ? beat_word : '0;
  assign sram.y_wmask = {BYTE_W{wr}};
  assign busy         = (state != IDLE);
  assign row_done     = (state == DONE);

endmodule

// File: tb/tb_y_tile_row_to_sram.sv
// tb/tb_y_tile_row_to_sram.sv - scoreboard bench for the tile row writeback engine
module tb_y_tile_row_to_sram;

  localparam int N      = 8;
  localparam int KMAX   = 1024;
  localparam int DATA_W = 32;
  localparam int K_W    = 10;
  localparam int N_W    = 3;
  localparam int BYTE_W = 4;

  typedef logic [49:0] beat_t;  // {re, k, n, wmask, wdata}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic                     start_k = 1'b0;
  logic [K_W-1:0]           k_idx = '0;
  logic                     row_ack = 1'b0;
  logic                     busy, row_done;
  logic [KMAX*N*DATA_W-1:0] flat;

  y_tile_row_to_sram_if #(.K_W(K_W), .N_W(N_W), .DATA_W(DATA_W)) sram_if ();

  y_tile_row_to_sram dut (
    .clk         (clk),
    .rst         (rst),
    .start_k     (start_k),
    .k_idx       (k_idx),
    .busy        (busy),
    .row_done    (row_done),
    .row_ack     (row_ack),
    .Y_tile_flat (flat),
    .sram        (sram_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int gnt_mode = 0;   // 0: always granted, 1: alternate from start, 2: random
  int alt_base = 0;
  beat_t sb[$];
  beat_t mon_act, mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] yval(input int k, input int n);
    return 32'hC000_0000 + (k << 16) + n;
  endfunction

  function automatic beat_t mk(input int k, input int n, input logic [31:0] d);
    return {1'b0, K_W'(k), N_W'(n), 4'hF, d};
  endfunction

  // Queue the beats the SRAM should see: count beats, zeros from column zero_from on.
  task automatic push_row(input int k, input int zero_from, input int count);
    for (int n = 0; n < count; n++)
      sb.push_back(mk(k, n, (n >= zero_from) ? 32'h0 : yval(k, n)));
  endtask

  task automatic fill_row(input int k);
    for (int n = 0; n < N; n++) flat[(k*N+n)*DATA_W +: DATA_W] = yval(k, n);
  endtask

  // Grant driver: value set after edge c applies at edge c+1.
  always @(posedge clk) begin
    #2;
    case (gnt_mode)
      0:       sram_if.y_gnt = 1'b1;
      1:       sram_if.y_gnt = ((cyc - alt_base) % 2) == 0;
      default: sram_if.y_gnt = 1'($urandom_range(0, 1));
    endcase
  end

  // Fake SRAM / monitor: a beat is written at the edge following this sample.
  always @(negedge clk) begin
    if (!rst && sram_if.y_en && sram_if.y_we && sram_if.y_gnt) begin
      mon_act = {sram_if.y_re, sram_if.y_k, sram_if.y_n, sram_if.y_wmask, sram_if.y_wdata};
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_write actual=%h required=none (cycle %0d)", mon_act, cyc);
      end else begin
        mon_exp = sb.pop_front();
        check("beat", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  task automatic do_start(input int k, output int t0);
    @(negedge clk);
    start_k  = 1'b1;
    k_idx    = K_W'(k);
    alt_base = cyc + 1;
    @(posedge clk);
    #1;
    t0      = cyc;
    start_k = 1'b0;
  endtask

  task automatic wait_done(input string name, output int rise);
    rise = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (row_done) begin
        rise = cyc + 1;
        break;
      end
    end
    if (rise < 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_row_done required=row_done", name);
    end
  endtask

  task automatic do_ack(input logic with_start);
    @(negedge clk);
    row_ack = 1'b1;
    if (with_start) begin
      start_k = 1'b1;
      k_idx   = K_W'(11);
    end
    @(posedge clk);
    #1;
    row_ack = 1'b0;
    start_k = 1'b0;
    check("ack_busy", 64'(busy), 64'(0));
    check("ack_row_done", 64'(row_done), 64'(0));
  endtask

  function automatic logic [63:0] outs_all();
    return 64'({busy, row_done, sram_if.y_en, sram_if.y_we, sram_if.y_re, sram_if.y_k,
                sram_if.y_n, sram_if.y_wmask}) | 64'(sram_if.y_wdata);
  endfunction

  initial begin
    int t0, rise, k;
    for (int kk = 0; kk < KMAX; kk++) fill_row(kk);
    sram_if.y_gnt = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs_all(), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Row 0, always granted.
    gnt_mode = 0;
    push_row(0, N, N);
    do_start(0, t0);
    check("start_busy", 64'(busy), 64'(1));
    check("start_en_we", 64'({sram_if.y_en, sram_if.y_we}), 64'(2'b11));
    wait_done("k0", rise);
    check("k0_done_cycle", 64'(rise), 64'(t0 + 9));
    check("k0_all_written", 64'(sb.size()), 64'(0));
    do_ack(1'b0);

    // Row 9, grant low every other cycle.
    gnt_mode = 1;
    push_row(9, N, N);
    do_start(9, t0);
    wait_done("k9_alt", rise);
    check("k9_done_cycle", 64'(rise), 64'(t0 + 16));
    check("k9_all_written", 64'(sb.size()), 64'(0));
    do_ack(1'b0);

    // Starts during WRITE and with the ack are dropped.
    gnt_mode = 0;
    push_row(3, N, N);
    do_start(3, t0);
    @(negedge clk);
    start_k = 1'b1;
    k_idx   = K_W'(7);
    @(negedge clk);
    start_k = 1'b0;
    wait_done("k3", rise);
    check("k3_done_cycle", 64'(rise), 64'(t0 + 9));
    do_ack(1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("no_restart_busy", 64'(busy), 64'(0));
    check("no_restart_queue", 64'(sb.size()), 64'(0));

    // Reset after beat 3 of row 5, then rewrite the whole row.
    push_row(5, N, 4);
    do_start(5, t0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_outputs", outs_all(), 64'(0));
    check("mid_reset_beats", 64'(sb.size()), 64'(0));
    rst = 1'b0;
    push_row(5, N, N);
    do_start(5, t0);
    wait_done("k5_redo", rise);
    check("k5_done_cycle", 64'(rise), 64'(t0 + 9));
    check("k5_all_written", 64'(sb.size()), 64'(0));
    do_ack(1'b0);

    // Source row overwritten with zeros two cycles into the row.
`ifdef YROW_SNAPSHOT_EN
    push_row(9, N, N);
`else
    push_row(9, 2, N);
`endif
    do_start(9, t0);
    repeat (2) @(posedge clk);
    #1;
    flat[9*N*DATA_W +: N*DATA_W] = '0;
    wait_done("k9_zero", rise);
    check("k9_zero_written", 64'(sb.size()), 64'(0));
    do_ack(1'b0);
    fill_row(9);

    // Random rows under random grant.
    gnt_mode = 2;
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(0, KMAX - 1);
      push_row(k, N, N);
      do_start(k, t0);
      wait_done("rand", rise);
      check("rand_all_written", 64'(sb.size()), 64'(0));
      do_ack(1'b0);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
